// File: rtl/fifo_gearbox_down.sv
// Width-downsizing FIFO: stores IN_WIDTH-bit words in a circular buffer and
// presents each stored word as RATIO narrow lanes in a build-time lane order.
module fifo_gearbox_down #(
    parameter int OUT_WIDTH  = 16,
    parameter int RATIO      = 2,
    parameter int DEPTH      = 512,
    parameter int CNTR_WIDTH = 9,
    parameter int MSB_FIRST  = 1,
    localparam int IN_WIDTH  = OUT_WIDTH * RATIO,
    localparam int LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                  dsp_clk,
    input  logic                  dsp_rst,
    input  logic                  clr_i,
    input  logic [IN_WIDTH-1:0]   dat_i,
    input  logic                  enq_en_i,
    output logic                  enq_rdy_o,
    output logic [OUT_WIDTH-1:0]  dat_o,
    input  logic                  deq_en_i,
    output logic                  deq_rdy_o,
    output logic [CNTR_WIDTH:0]   count_o,
    output logic [LANE_W-1:0]     lane_o,
    output logic                  last_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int NUM_SLOTS = 1 << LANE_W;
    localparam logic [CNTR_WIDTH:0]   DEPTH_CNT = (CNTR_WIDTH + 1)'(DEPTH);
    localparam logic [CNTR_WIDTH-1:0] PTR_LAST  = CNTR_WIDTH'(DEPTH - 1);
    localparam logic [LANE_W-1:0]     LANE_LAST = LANE_W'(RATIO - 1);

    logic [IN_WIDTH-1:0]   mem [DEPTH];
    logic [CNTR_WIDTH-1:0] wp_q, wp_d;
    logic [CNTR_WIDTH-1:0] rp_q, rp_d;
    logic [CNTR_WIDTH:0]   cnt_q, cnt_d;
    logic [LANE_W-1:0]     lane_q, lane_d;

    logic                  enq_fire;
    logic                  deq_fire;
    logic                  pop;
    logic                  mem_we;
    logic [IN_WIDTH-1:0]   head;
    logic [LANE_W-1:0]     sel;
    logic [OUT_WIDTH-1:0]  lanes [NUM_SLOTS];

    always_comb begin
        enq_rdy_o = (cnt_q < DEPTH_CNT);
        deq_rdy_o = (cnt_q != '0);
        enq_fire  = enq_en_i & enq_rdy_o;
        deq_fire  = deq_en_i & deq_rdy_o;
        pop       = deq_fire & (lane_q == LANE_LAST);
        mem_we    = enq_fire & ~clr_i & ~dsp_rst;

        wp_d = wp_q;
        if (enq_fire) begin
            wp_d = (wp_q == PTR_LAST) ? '0 : wp_q + 1'b1;
        end

        rp_d = rp_q;
        if (pop) begin
            rp_d = (rp_q == PTR_LAST) ? '0 : rp_q + 1'b1;
        end

        lane_d = lane_q;
        if (deq_fire) begin
            lane_d = pop ? '0 : lane_q + 1'b1;
        end

        // A simultaneous push and pop leaves the occupancy unchanged.
        cnt_d = cnt_q;
        case ({enq_fire, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (clr_i) begin
            wp_d   = '0;
            rp_d   = '0;
            cnt_d  = '0;
            lane_d = '0;
        end
    end

    always_ff @(posedge dsp_clk) begin
        if (dsp_rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            lane_q <= '0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            lane_q <= lane_d;
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge dsp_clk) begin
        if (mem_we) begin
            mem[wp_q[ADDR_W-1:0]] <= dat_i;
        end
    end

    // Lane table is padded to a power of two so the lane index always fits it.
    assign head = mem[rp_q[ADDR_W-1:0]];

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_lane
        if (i < RATIO) begin : g_used
            assign lanes[i] = head[i*OUT_WIDTH +: OUT_WIDTH];
        end else begin : g_pad
            assign lanes[i] = '0;
        end
    end

    always_comb begin
        sel = (MSB_FIRST != 0) ? (LANE_LAST - lane_q) : lane_q;
    end

    assign dat_o   = lanes[sel];
    assign count_o = cnt_q;
    assign lane_o  = lane_q;
    assign last_o  = (lane_q == LANE_LAST);

endmodule

// File: doc/fifo_gearbox_down.md
# fifo_gearbox_down

Parametrised width-downsizing FIFO for the USRP2 u2plus DSP clock domain: buffers words of RATIO×OUT_WIDTH bits and emits them as RATIO narrow lanes per word, in a lane order fixed at build time. It generalises the fixed 32-in/16-out TX buffer to any lane width, ratio and depth. Its own circular storage adds a synchronous clear, an occupancy count and lane/last-lane status. It sits between the host-side packet path and the narrow per-sample TX pipeline.

## Interface
- OUT_WIDTH, 16, output lane width in bits (≥1)
- RATIO, 2, lanes per input word (≥1); input width is IN_WIDTH = OUT_WIDTH×RATIO
- DEPTH, 512, storage depth in input words (≥2, any integer)
- CNTR_WIDTH, 9, pointer width; DEPTH ≤ 2^CNTR_WIDTH
- MSB_FIRST, 1, 1: most-significant lane first; 0: least-significant lane first

- dsp_clk  in  1  sole clock, all logic on rising edge
- dsp_rst  in  1  synchronous, active-high reset
- clr_i  in  1  synchronous clear: empty storage, lane index to 0
- dat_i  in  IN_WIDTH  input word
- enq_en_i  in  1  enqueue strobe, honoured only when enq_rdy_o=1
- enq_rdy_o  out  1  space for one word
- dat_o  out  OUT_WIDTH  current lane of head word (first-word-fall-through)
- deq_en_i  in  1  consume current lane, honoured only when deq_rdy_o=1
- deq_rdy_o  out  1  head word present
- count_o  out  CNTR_WIDTH+1  words stored, including the partially drained head
- lane_o  out  max(1,clog2(RATIO))  index of lane on dat_o
- last_o  out  1  lane_o == RATIO-1

## Operation
- Storage: DEPTH×IN_WIDTH array, write pointer wp, read pointer rp, counter cnt. Pointers wrap from DEPTH-1 to 0 explicitly; no power-of-two requirement.
- enq_rdy_o = (cnt < DEPTH); deq_rdy_o = (cnt ≠ 0); count_o = cnt.
- Accepted enqueue (enq_en_i & enq_rdy_o): mem[wp] ← dat_i; wp advances. enq_en_i while full is dropped silently; storage, wp and cnt are unchanged.
- Lane select, head word H = mem[rp]:
  - MSB_FIRST=1: dat_o = H[(RATIO-1-lane)×OUT_WIDTH +: OUT_WIDTH]
  - MSB_FIRST=0: dat_o = H[lane×OUT_WIDTH +: OUT_WIDTH]
- Accepted dequeue (deq_en_i & deq_rdy_o):
  - if lane < RATIO-1: lane increments.
  - if lane = RATIO-1: lane ← 0, rp advances, head word popped.
- deq_en_i while empty is ignored; the lane index does not move.
- RATIO=1: every accepted dequeue pops a word; last_o is tied to 1; lane_o is tied to 0.
- cnt update per cycle: +1 on accepted enqueue without pop; −1 on pop without accepted enqueue; unchanged when both or neither occur.
- Priority: dsp_rst > clr_i > normal operation. clr_i or reset forces wp=rp=cnt=lane=0. Any enq or deq in the same cycle is discarded, and a partially drained word is lost.
- Storage contents are not reset.

## Timing
- Reset values: enq_rdy_o=1, deq_rdy_o=0, count_o=0, lane_o=0, last_o=(RATIO==1). dat_o is undefined while deq_rdy_o=0.
- Enqueue-to-output latency: a word accepted into an empty FIFO at edge N shows on dat_o with deq_rdy_o=1 after edge N. dat_o is combinational from registered mem/rp/lane (no bypass).
- Each lane is valid before the edge that consumes it. The next lane appears the cycle after an accepted dequeue.
- Sustained throughput: one lane per cycle out, one word per cycle in. Input must average ≤1 word per RATIO cycles to avoid full.
- Full with simultaneous pop: enq_rdy_o stays 0 that cycle and the enqueue is refused. enq_rdy_o rises the following cycle.
- Empty with simultaneous enqueue and deq_en_i: the dequeue is ignored and the word is retained.
- clr_i or dsp_rst mid-word: the next cycle shows empty state, and lane_o=0 for the next word.

## Test plan
- Reset/idle: assert dsp_rst 2 cycles → enq_rdy_o=1, deq_rdy_o=0, count_o=0, lane_o=0. deq_en_i pulses while empty → lane_o stays 0.
- Lane order, OUT_WIDTH=16, RATIO=2:
  - MSB_FIRST=1: enqueue 0xAAAA5555, deq twice → dat_o 0xAAAA then 0x5555; last_o 0 then 1; count_o 1→0 after second deq.
  - MSB_FIRST=0: same stimulus → dat_o 0x5555 then 0xAAAA.
- Ratio 4, OUT_WIDTH=8, MSB_FIRST=1: enqueue 0x11223344 and 0xAABBCCDD back-to-back, deq_en_i held high → dat_o 11,22,33,44,AA,BB,CC,DD on consecutive cycles; deq_rdy_o falls after DD.
- Full/wrap, DEPTH=5: enqueue 0..4 → enq_rdy_o=0, count_o=5.
  - Extra enqueue of 0xFF → dropped.
  - Drain two words while enqueuing 5,6 → pointers wrap; full drain yields 2,3,4,5,6 in order, no 0xFF.
- Simultaneous full+pop: full, last-lane dequeue with enq_en_i=1 → enqueue refused, count_o=DEPTH−1. enq_rdy_o=1 next cycle.
- Clear mid-word: enqueue 3 words, deq one lane, assert clr_i with enq_en_i=1 → count_o=0, lane_o=0, deq_rdy_o=0. Next enqueued word is output from its first lane.
